// File: rtl/card_pkg.sv
// Shared card constants, rank encoding, value mapping and dealer state type.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package card_pkg;

  localparam int CARDS_PER_DECK = 52;
  localparam int SUITS          = 4;

  typedef enum logic [3:0] {
    RANK_ACE   = 4'd1,
    RANK_TWO   = 4'd2,
    RANK_THREE = 4'd3,
    RANK_FOUR  = 4'd4,
    RANK_FIVE  = 4'd5,
    RANK_SIX   = 4'd6,
    RANK_SEVEN = 4'd7,
    RANK_EIGHT = 4'd8,
    RANK_NINE  = 4'd9,
    RANK_TEN   = 4'd10,
    RANK_JACK  = 4'd11,
    RANK_QUEEN = 4'd12,
    RANK_KING  = 4'd13
  } rank_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    SCAN = 2'd2
  } state_e;

  // Blackjack-style value: picture cards count as ten.
  function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
    return (rank > 4'd10) ? 4'd10 : rank;
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR with synchronous seed load; a zero load value is forced to 1.
// Latency: state updates one clock after load/shift.
// Backpressure: none, free-running every cycle out of reset.
module lfsr_gen #(
  parameter int                    LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = LFSR_WIDTH'(16'hD008),
  parameter logic [LFSR_WIDTH-1:0] SEED       = LFSR_WIDTH'(16'h0002)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [LFSR_WIDTH-1:0] load_val,
  output logic [LFSR_WIDTH-1:0] state
);

  localparam logic [LFSR_WIDTH-1:0] ONE = {{(LFSR_WIDTH-1){1'b0}}, 1'b1};

  logic [LFSR_WIDTH-1:0] state_q, state_d;

  // Next state: a load wins over the shift; the all-zero lock-up state is never loaded.
  always_comb begin
    state_d = {state_q[LFSR_WIDTH-2:0], ^(state_q & TAPS)};
    if (load) begin
      state_d = (load_val == '0) ? ONE : load_val;
    end
  end

  // State register with synchronous reset to the seed.
  always_ff @(posedge clk) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/card_shoe.sv
// Multi-deck card shoe dealt without replacement, draw by request/valid pulse.
// Latency: card_valid 2 cycles after draw_req best case, 2+MAX_TRIES+12 worst case.
// Backpressure: draw_req is ignored while busy; shuffle aborts any draw in flight.
module card_shoe
  import card_pkg::*;
#(
  parameter int                    NUM_DECKS  = 1,
  parameter int                    LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = LFSR_WIDTH'(16'hD008),
  parameter logic [LFSR_WIDTH-1:0] SEED       = LFSR_WIDTH'(16'h0002),
  parameter int                    MAX_TRIES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  draw_req,
  input  logic                  shuffle,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed_in,
  output logic                  card_valid,
  output logic [3:0]            card_rank,
  output logic [3:0]            card_value,
  output logic                  draw_err,
  output logic                  busy,
  output logic                  empty,
  output logic [8:0]            cards_left
);

  localparam int              NRANKS     = 13;
  localparam int              TW         = $clog2(MAX_TRIES + 1);
  localparam logic [5:0]      FULL_CNT   = 6'(SUITS * NUM_DECKS);
  localparam logic [8:0]      FULL_LEFT  = 9'(CARDS_PER_DECK * NUM_DECKS);
  localparam logic [TW-1:0]   TRIES_LAST = TW'(MAX_TRIES - 1);
  localparam logic [3:0]      LAST_IDX   = 4'(RANK_KING) - 4'(RANK_ACE);

  state_e          state_q;
  logic [5:0]      cnt_q [NRANKS];
  logic [8:0]      left_q;
  logic            empty_q, busy_q, valid_q, err_q;
  logic [3:0]      rank_q, value_q;
  logic [TW-1:0]   tries_q;
  logic [3:0]      idx_q;

  logic [LFSR_WIDTH-1:0] lfsr;
  logic                  lfsr_unused;
  logic [3:0]            r, r_safe, r_wrap;
  logic                  r_ok;
  logic                  deal_d;
  logic [3:0]            deal_idx_d;

  lfsr_gen #(
    .LFSR_WIDTH (LFSR_WIDTH),
    .TAPS       (TAPS),
    .SEED       (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_load),
    .load_val (seed_in),
    .state    (lfsr)
  );

  // Only the low nibble picks a rank; the rest of the LFSR just decorrelates it.
  assign lfsr_unused = ^lfsr[LFSR_WIDTH-1:4];
  assign r      = lfsr[3:0];
  assign r_ok   = (r <= LAST_IDX);
  assign r_safe = r_ok ? r : 4'd0;
  assign r_wrap = r_ok ? r : (r - 4'(NRANKS));

  // Deal decision for the current PICK candidate or SCAN pointer.
  always_comb begin
    deal_d     = 1'b0;
    deal_idx_d = idx_q;
    case (state_q)
      PICK: begin
        deal_idx_d = r_safe;
        deal_d     = r_ok && (cnt_q[r_safe] != 6'd0);
      end
      SCAN: begin
        deal_d = (cnt_q[idx_q] != 6'd0);
      end
      default: ;
    endcase
  end

  // Dealer FSM with registered outputs; shuffle refills and aborts from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < NRANKS; i++) cnt_q[i] <= FULL_CNT;
      left_q  <= FULL_LEFT;
      empty_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rank_q  <= 4'd0;
      value_q <= 4'd0;
      tries_q <= '0;
      idx_q   <= 4'd0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (shuffle) begin
        for (int i = 0; i < NRANKS; i++) cnt_q[i] <= FULL_CNT;
        left_q  <= FULL_LEFT;
        empty_q <= 1'b0;
        busy_q  <= 1'b0;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (draw_req) begin
              if (empty_q) begin
                err_q <= 1'b1;
              end else begin
                state_q <= PICK;
                busy_q  <= 1'b1;
                tries_q <= '0;
              end
            end
          end
          PICK: begin
            if (!deal_d) begin
              if (tries_q == TRIES_LAST) begin
                state_q <= SCAN;
                idx_q   <= r_wrap;
              end else begin
                tries_q <= tries_q + 1'b1;
              end
            end
          end
          SCAN: begin
            if (!deal_d) idx_q <= (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
          end
          default: state_q <= IDLE;
        endcase
        if (deal_d) begin
          cnt_q[deal_idx_d] <= cnt_q[deal_idx_d] - 6'd1;
          left_q  <= left_q - 9'd1;
          empty_q <= (left_q == 9'd1);
          valid_q <= 1'b1;
          rank_q  <= deal_idx_d + 4'(RANK_ACE);
          value_q <= rank_to_value(deal_idx_d + 4'(RANK_ACE));
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      end
    end
  end

  assign card_valid = valid_q;
  assign card_rank  = rank_q;
  assign card_value = value_q;
  assign draw_err   = err_q;
  assign busy       = busy_q;
  assign empty      = empty_q;
  assign cards_left = left_q;

endmodule

// File: tb/tb_card_shoe.sv
// Scoreboard bench for card_shoe: stimulus queues expected cards/errors, monitor checks them.
// Two instances: default MAX_TRIES and MAX_TRIES=1 for the linear-scan fallback.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_card_shoe;

  typedef struct {
    int rank;   // 0 means any legal rank
    int lmin;
    int lmax;
    int req;    // cycle number of the edge that samples draw_req
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        draw_req = 1'b0, shuffle = 1'b0, seed_load = 1'b0;
  logic [15:0] seed_in = 16'h0000;
  logic        sel = 1'b0;

  logic        a_cv, a_err, a_busy, a_empty, b_cv, b_err, b_busy, b_empty;
  logic [3:0]  a_rank, a_value, b_rank, b_value;
  logic [8:0]  a_left, b_left;
  logic        m_cv, m_err, m_busy, m_empty;
  logic [3:0]  m_rank, m_value;
  logic [8:0]  m_left;

  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t exp_q[$];
  int   err_q[$];
  int   got_q[$];
  int   rec[$];
  int   hist[16];
  int   vsum = 0;
  int   errs_seen = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  card_shoe dut_a (
    .clk(clk), .rst(rst),
    .draw_req(draw_req & ~sel), .shuffle(shuffle & ~sel),
    .seed_load(seed_load & ~sel), .seed_in(seed_in),
    .card_valid(a_cv), .card_rank(a_rank), .card_value(a_value),
    .draw_err(a_err), .busy(a_busy), .empty(a_empty), .cards_left(a_left)
  );

  card_shoe #(.MAX_TRIES(1)) dut_b (
    .clk(clk), .rst(rst),
    .draw_req(draw_req & sel), .shuffle(shuffle & sel),
    .seed_load(seed_load & sel), .seed_in(seed_in),
    .card_valid(b_cv), .card_rank(b_rank), .card_value(b_value),
    .draw_err(b_err), .busy(b_busy), .empty(b_empty), .cards_left(b_left)
  );

  assign m_cv    = sel ? b_cv    : a_cv;
  assign m_err   = sel ? b_err   : a_err;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_empty = sel ? b_empty : a_empty;
  assign m_rank  = sel ? b_rank  : a_rank;
  assign m_value = sel ? b_value : a_value;
  assign m_left  = sel ? b_left  : a_left;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every card or error pulse must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    int   ev;
    if (m_cv) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_card_valid", 1, 0);
      end else begin
        e   = exp_q.pop_front();
        lat = cyc - e.req + 1;
        if (e.rank != 0) chk("card_rank", int'(m_rank), e.rank);
        else             chk("card_rank_legal", int'(m_rank >= 4'd1 && m_rank <= 4'd13), 1);
        ev = (m_rank > 4'd10) ? 10 : int'(m_rank);
        chk("card_value", int'(m_value), ev);
        chk("latency_min_ok", int'(lat >= e.lmin), 1);
        chk("latency_max_ok", int'(lat <= e.lmax), 1);
        got_q.push_back(int'(m_rank));
        hist[m_rank] = hist[m_rank] + 1;
        vsum = vsum + int'(m_value);
      end
    end
    if (m_err) begin
      errs_seen++;
      if (err_q.size() == 0) chk("unexpected_draw_err", 1, 0);
      else                   chk("draw_err_cycle", cyc, err_q.pop_front());
    end
  end

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0 || err_q.size() != 0) begin
      chk("response_timeout_pending", exp_q.size() + err_q.size(), 0);
      exp_q.delete();
      err_q.delete();
    end
  endtask

  task automatic do_draw(input int rank, input int lmin, input int lmax,
                         input bit ld, input logic [15:0] sv, input bit rel);
    exp_t e;
    @(negedge clk);
    if (rel) rst = 1'b0;
    draw_req  = 1'b1;
    seed_load = ld;
    seed_in   = sv;
    e.rank = rank; e.lmin = lmin; e.lmax = lmax; e.req = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    draw_req  = 1'b0;
    seed_load = 1'b0;
    seed_in   = 16'h0000;
    chk("busy_during_pick", int'(m_busy), 1);
    drain(40);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_card_valid"}, int'(m_cv), 0);
    chk({tag, "_card_rank"},  int'(m_rank), 0);
    chk({tag, "_card_value"}, int'(m_value), 0);
    chk({tag, "_draw_err"},   int'(m_err), 0);
    chk({tag, "_busy"},       int'(m_busy), 0);
    chk({tag, "_empty"},      int'(m_empty), 0);
    chk({tag, "_cards_left"}, int'(m_left), 52);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) hist[i] = 0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");

    // First draw after reset: LFSR 0x0002 -> 0x0004 at the request edge, so rank 5.
    do_draw(5, 2, 2, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 51; i++) do_draw(0, 2, 18, 1'b0, 16'h0000, 1'b0);
    for (int k = 1; k <= 13; k++) chk($sformatf("rank_%0d_dealt_count", k), hist[k], 4);
    chk("value_sum_52", vsum, 340);
    chk("empty_after_52", int'(m_empty), 1);
    chk("cards_left_after_52", int'(m_left), 0);
    chk("draw_err_during_52", errs_seen, 0);

    // Draw from an empty shoe.
    @(negedge clk);
    draw_req = 1'b1;
    err_q.push_back(cyc + 1);
    @(negedge clk);
    draw_req = 1'b0;
    chk("busy_on_empty_draw", int'(m_busy), 0);
    drain(10);
    repeat (3) @(negedge clk);
    chk("cards_left_after_err", int'(m_left), 0);

    // Shuffle refills.
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    chk("cards_left_after_shuffle", int'(m_left), 52);
    chk("empty_after_shuffle", int'(m_empty), 0);

    // Seed load: PICK sees the loaded value, zero acts as one.
    do_draw(2, 2, 2, 1'b1, 16'h0000, 1'b0);
    do_draw(2, 2, 2, 1'b1, 16'h0001, 1'b0);
    do_draw(4, 2, 2, 1'b1, 16'h0003, 1'b0);
    chk("cards_left_after_seeded", int'(m_left), 49);

    // Reproducibility across resets.
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    got_q.delete();
    for (int i = 0; i < 10; i++) do_draw((i == 0) ? 5 : 0, 2, 18, 1'b0, 16'h0000, i == 0);
    rec = got_q;
    chk("recorded_draws", rec.size(), 10);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) do_draw(rec[i], 2, 18, 1'b0, 16'h0000, i == 0);

    // Shuffle in the PICK cycle aborts the draw.
    @(negedge clk);
    draw_req = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    chk("busy_before_abort", int'(m_busy), 1);
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    chk("busy_after_abort", int'(m_busy), 0);
    chk("cards_left_after_abort", int'(m_left), 52);
    repeat (20) @(negedge clk);

    // Shuffle and draw_req together: draw dropped.
    do_draw(0, 2, 18, 1'b0, 16'h0000, 1'b0);
    chk("cards_left_before_combo", int'(m_left), 51);
    @(negedge clk);
    draw_req = 1'b1;
    shuffle  = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    shuffle  = 1'b0;
    chk("busy_after_combo", int'(m_busy), 0);
    chk("cards_left_after_combo", int'(m_left), 52);
    repeat (20) @(negedge clk);

    // Reset during PICK.
    @(negedge clk);
    draw_req = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midpick_reset");
    do_draw(5, 2, 2, 1'b0, 16'h0000, 1'b1);

    // Scan fallback on the MAX_TRIES=1 instance: steer ranks 1..12 out, then only kings remain.
    @(negedge clk);
    sel = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("scan_unit_cards_left_full", int'(m_left), 52);
    for (int k = 1; k <= 12; k++)
      for (int j = 0; j < 4; j++)
        do_draw(k, 2, 2, 1'b1, {12'h001, 4'(k - 1)}, 1'b0);
    chk("scan_unit_cards_left_4", int'(m_left), 4);
    for (int j = 0; j < 4; j++) do_draw(13, 2, 15, 1'b0, 16'h0000, 1'b0);
    chk("scan_unit_cards_left_0", int'(m_left), 0);
    chk("scan_unit_empty", int'(m_empty), 1);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", compared);
    $fatal(1, "watchdog");
  end

endmodule
